// File: rtl/riscv_pkg.sv
// Shared RV32I memory-stage types: load/store opcodes, MEM FSM states, bus widths.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int WSTRB_W = XLEN / 8;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  function automatic logic is_store(mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Memory controller bus: the MEM stage is master, the controller is slave.
interface memory_access_unit_if;
  import riscv_pkg::*;

  logic               mem_req;
  logic               mem_we;
  logic [XLEN-1:0]    mem_addr;
  logic [XLEN-1:0]    mem_wdata;
  logic [WSTRB_W-1:0] mem_wstrb;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [XLEN-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication and strobes, load extract and
// sign/zero extension, and misalignment detection.
module mem_lane_align
  import riscv_pkg::*;
(
  input  mem_op_e            op,
  input  logic [1:0]         byte_off,
  input  logic [XLEN-1:0]    store_data,
  input  logic [XLEN-1:0]    rdata,
  output logic [XLEN-1:0]    wdata,
  output logic [WSTRB_W-1:0] wstrb,
  output logic [XLEN-1:0]    load_data,
  output logic               misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    wdata      = '0;
    wstrb      = '0;
    load_data  = '0;
    misaligned = 1'b0;
    byte_sel   = rdata[{byte_off, 3'b000} +: 8];
    half_sel   = rdata[{byte_off[1], 4'b0000} +: 16];
    case (op)
      MEM_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data = {24'h0, byte_sel};
      MEM_LH: begin
        misaligned = byte_off[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
      end
      MEM_LHU: begin
        misaligned = byte_off[0];
        load_data  = {16'h0, half_sel};
      end
      MEM_LW: begin
        misaligned = |byte_off;
        load_data  = rdata;
      end
      MEM_SB: begin
        wstrb = 4'b0001 << byte_off;
        wdata = {4{store_data[7:0]}};
      end
      MEM_SH: begin
        misaligned = byte_off[0];
        wstrb      = 4'b0011 << {byte_off[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
      end
      MEM_SW: begin
        misaligned = |byte_off;
        wstrb      = 4'b1111;
        wdata      = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// RV32I MEM stage: accepts one execute result per handshake, runs the memory
// bus cycle for loads/stores and emits a one-cycle write-back pulse.
module memory_access_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  mem_op_e               ex_op,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] ex_rs2_data,
  input  logic [4:0]            ex_rd_addr,
  input  logic                  ex_rd_we,
  memory_access_unit_if.master  mem,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd_addr,
  output logic                  wb_rd_we,
  output logic [DATA_WIDTH-1:0] wb_rd_data,
  output logic                  misalign_exc,
  output logic [ADDR_WIDTH-1:0] misalign_addr
);

  mem_state_e         state_q, state_d;
  mem_op_e            op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic [4:0]         rd_addr_q, rd_addr_d;
  logic               rd_we_q, rd_we_d;
  logic               ex_ready_q, ex_ready_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [XLEN-1:0]    mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
  logic [WSTRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_addr_q, wb_rd_addr_d;
  logic               wb_rd_we_q, wb_rd_we_d;
  logic [XLEN-1:0]    wb_rd_data_q, wb_rd_data_d;
  logic               misalign_exc_q, misalign_exc_d;
  logic [XLEN-1:0]    misalign_addr_q, misalign_addr_d;

  mem_op_e            la_op;
  logic [1:0]         la_off;
  logic [XLEN-1:0]    la_wdata, la_load_data;
  logic [WSTRB_W-1:0] la_wstrb;
  logic               la_misaligned;

  // The aligner sees the incoming op while idle and the captured op afterwards.
  assign la_op  = (state_q == IDLE) ? ex_op : op_q;
  assign la_off = (state_q == IDLE) ? ex_result[1:0] : off_q;

  mem_lane_align u_lane_align (
    .op         (la_op),
    .byte_off   (la_off),
    .store_data (ex_rs2_data),
    .rdata      (mem.mem_rdata),
    .wdata      (la_wdata),
    .wstrb      (la_wstrb),
    .load_data  (la_load_data),
    .misaligned (la_misaligned)
  );

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    off_d           = off_q;
    rd_addr_d       = rd_addr_q;
    rd_we_d         = rd_we_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    wb_valid_d      = 1'b0;
    wb_rd_addr_d    = wb_rd_addr_q;
    wb_rd_we_d      = wb_rd_we_q;
    wb_rd_data_d    = wb_rd_data_q;
    misalign_exc_d  = 1'b0;
    misalign_addr_d = misalign_addr_q;

    unique case (state_q)
      IDLE: if (ex_valid && ex_ready_q) begin
        op_d         = ex_op;
        off_d        = ex_result[1:0];
        rd_addr_d    = ex_rd_addr;
        rd_we_d      = ex_rd_we;
        wb_rd_addr_d = ex_rd_addr;
        if (ex_op == MEM_NONE) begin
          state_d      = RESP;
          wb_valid_d   = 1'b1;
          wb_rd_we_d   = ex_rd_we;
          wb_rd_data_d = ex_result;
        end else if (la_misaligned) begin
          state_d         = RESP;
          wb_valid_d      = 1'b1;
          wb_rd_we_d      = 1'b0;
          wb_rd_data_d    = '0;
          misalign_exc_d  = 1'b1;
          misalign_addr_d = ex_result;
        end else begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store(ex_op);
          mem_addr_d  = {ex_result[XLEN-1:2], 2'b00};
          mem_wdata_d = la_wdata;
          mem_wstrb_d = la_wstrb;
        end
      end
      REQ: if (mem.mem_gnt) begin
        mem_req_d = 1'b0;
        if (mem_we_q) begin
          state_d      = RESP;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = rd_addr_q;
          wb_rd_we_d   = 1'b0;
          wb_rd_data_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (mem.mem_rvalid) begin
        state_d      = RESP;
        wb_valid_d   = 1'b1;
        wb_rd_addr_d = rd_addr_q;
        wb_rd_we_d   = rd_we_q && (rd_addr_q != 5'd0);
        wb_rd_data_d = la_load_data;
      end
      RESP: state_d = IDLE;
    endcase

    ex_ready_d = (state_d == IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      op_q            <= MEM_NONE;
      off_q           <= '0;
      rd_addr_q       <= '0;
      rd_we_q         <= 1'b0;
      ex_ready_q      <= 1'b1;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_addr_q    <= '0;
      wb_rd_we_q      <= 1'b0;
      wb_rd_data_q    <= '0;
      misalign_exc_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      off_q           <= off_d;
      rd_addr_q       <= rd_addr_d;
      rd_we_q         <= rd_we_d;
      ex_ready_q      <= ex_ready_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_rd_we_q      <= wb_rd_we_d;
      wb_rd_data_q    <= wb_rd_data_d;
      misalign_exc_q  <= misalign_exc_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign ex_ready      = ex_ready_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd_addr    = wb_rd_addr_q;
  assign wb_rd_we      = wb_rd_we_q;
  assign wb_rd_data    = wb_rd_data_q;
  assign misalign_exc  = misalign_exc_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: reset, pass-through, stores, loads,
// misalignment, rd=0 loads, stray bus responses and reset abort.
module tb_memory_access_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  mem_op_e     ex_op;
  logic [31:0] ex_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_we;
  logic [31:0] wb_rd_data;
  logic        misalign_exc;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access_unit_if bus ();

  always #5 clk = ~clk;

  memory_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_op         (ex_op),
    .ex_result     (ex_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_rd_we      (ex_rd_we),
    .mem           (bus.master),
    .wb_valid      (wb_valid),
    .wb_rd_addr    (wb_rd_addr),
    .wb_rd_we      (wb_rd_we),
    .wb_rd_data    (wb_rd_data),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr)
  );

  // Presents one op for exactly one rising edge; returns at the first sample point after accept.
  task automatic issue(input mem_op_e op, input logic [31:0] res, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic we);
    @(negedge clk);
    ex_op = op; ex_result = res; ex_rs2_data = rs2; ex_rd_addr = rd; ex_rd_we = we;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ex_valid = 1'b0; ex_op = MEM_NONE; ex_result = '0; ex_rs2_data = '0;
    ex_rd_addr = '0; ex_rd_we = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #1 rst_n = 1'b0;
    #12;
    n_checks++;
    if ({ex_ready, bus.mem_req, bus.mem_we, wb_valid, wb_rd_we, misalign_exc} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {ex_ready, bus.mem_req, bus.mem_we, wb_valid, wb_rd_we, misalign_exc});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, wb_rd_data, misalign_addr, wb_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%b rd_data=%h mis_addr=%h rd=%0d want all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, wb_rd_data, misalign_addr, wb_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_none(input logic [31:0] res, input logic [4:0] rd, input string name);
    issue(MEM_NONE, res, 32'h0, rd, 1'b1);
    n_checks++;
    if ({wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data} !== {1'b1, 1'b1, rd, res}) begin
      n_fail++;
      $display("FAIL %s_wb: got v=%b we=%b rd=%0d data=%h want v=1 we=1 rd=%0d data=%h",
               name, wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, rd, res);
    end
    n_checks++;
    if ({bus.mem_req, ex_ready, misalign_exc} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_resp: got req=%b ready=%b exc=%b want 000", name, bus.mem_req, ex_ready, misalign_exc);
    end
    @(negedge clk);
    n_checks++;
    if ({wb_valid, ex_ready, bus.mem_req} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s_idle: got v=%b ready=%b req=%b want 010", name, wb_valid, ex_ready, bus.mem_req);
    end
  endtask

  task automatic test_sb_held();
    issue(MEM_SB, 32'h0000_0103, 32'hAABB_CCDD, 5'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, wb_valid}
          !== {1'b1, 1'b1, 4'b1000, 32'h0000_0100, 32'hDDDD_DDDD, 1'b0}) begin
        n_fail++;
        $display("FAIL sb_hold[%0d]: got req=%b we=%b strb=%b addr=%h wdata=%h v=%b want 1 1 1000 00000100 dddddddd 0",
                 k, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, wb_valid);
      end
      if (k == 2) bus.mem_gnt = 1'b1;
      @(negedge clk);
    end
    bus.mem_gnt = 1'b0;
    n_checks++;
    if ({wb_valid, wb_rd_we, bus.mem_req, ex_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL sb_retire: got v=%b we=%b req=%b ready=%b want 1000", wb_valid, wb_rd_we, bus.mem_req, ex_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({wb_valid, ex_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL sb_idle: got v=%b ready=%b want 01", wb_valid, ex_ready);
    end
  endtask

  task automatic test_store(input mem_op_e op, input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata, input string name);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    issue(op, addr, rs2, 5'd4, 1'b1);
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 1'b1, exp_strb, exp_addr, exp_wdata}) begin
      n_fail++;
      $display("FAIL %s_bus: got req=%b we=%b strb=%b addr=%h wdata=%h want 1 1 %b %h %h",
               name, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
               exp_strb, exp_addr, exp_wdata);
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    n_checks++;
    if ({wb_valid, wb_rd_we, bus.mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_retire: got v=%b we=%b req=%b want 100", name, wb_valid, wb_rd_we, bus.mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_load(input mem_op_e op, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_we,
                           input string name);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    issue(op, addr, 32'hFFFF_FFFF, rd, 1'b1);
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr} !== {1'b1, 1'b0, 4'b0000, exp_addr}) begin
      n_fail++;
      $display("FAIL %s_req: got req=%b we=%b strb=%b addr=%h want 1 0 0000 %h",
               name, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, exp_addr);
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    n_checks++;
    if ({bus.mem_req, wb_valid, ex_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_wait: got req=%b v=%b ready=%b want 000", name, bus.mem_req, wb_valid, ex_ready);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    n_checks++;
    if ({wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, misalign_exc} !== {1'b1, exp_we, rd, exp_data, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_wb: got v=%b we=%b rd=%0d data=%h exc=%b want v=1 we=%b rd=%0d data=%h exc=0",
               name, wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, misalign_exc, exp_we, rd, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign(input mem_op_e op, input logic [31:0] addr, input string name);
    issue(op, addr, 32'h1234_5678, 5'd6, 1'b1);
    n_checks++;
    if ({wb_valid, misalign_exc, wb_rd_we, bus.mem_req, misalign_addr} !== {4'b1100, addr}) begin
      n_fail++;
      $display("FAIL %s_exc: got v=%b exc=%b we=%b req=%b addr=%h want 1 1 0 0 %h",
               name, wb_valid, misalign_exc, wb_rd_we, bus.mem_req, misalign_addr, addr);
    end
    @(negedge clk);
    n_checks++;
    if ({wb_valid, misalign_exc, bus.mem_req, ex_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s_after: got v=%b exc=%b req=%b ready=%b want 0001",
               name, wb_valid, misalign_exc, bus.mem_req, ex_ready);
    end
  endtask

  task automatic test_stray_response();
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.mem_rdata  = 32'h1357_9BDF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({wb_valid, bus.mem_req, ex_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL stray_idle[%0d]: got v=%b req=%b ready=%b want 001", k, wb_valid, bus.mem_req, ex_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    issue(MEM_LW, 32'h0000_0500, 32'h0, 5'd3, 1'b1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ex_ready, bus.mem_req, wb_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_reset: got ready=%b req=%b v=%b want 100", ex_ready, bus.mem_req, wb_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({wb_valid, ex_ready, bus.mem_req} !== 3'b010) begin
        n_fail++;
        $display("FAIL abort_late_rvalid[%0d]: got v=%b ready=%b req=%b want 010", k, wb_valid, ex_ready, bus.mem_req);
      end
      @(negedge clk);
    end
    test_none(32'h0000_ABCD, 5'd12, "abort_none");
  endtask

  initial begin
    test_reset();
    test_none(32'h0000_1234, 5'd5, "none");
    test_sb_held();
    test_store(MEM_SH, 32'h0000_0102, 32'h1234_5678, 4'b1100, 32'h5678_5678, "sh_hi");
    test_store(MEM_SH, 32'h0000_0200, 32'h1234_5678, 4'b0011, 32'h5678_5678, "sh_lo");
    test_store(MEM_SB, 32'h0000_0201, 32'h0000_0011, 4'b0010, 32'h1111_1111, "sb_1");
    test_store(MEM_SW, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "sw");
    test_load(MEM_LB,  32'h0000_0202, 32'h0080_0000, 5'd7, 32'hFFFF_FF80, 1'b1, "lb");
    test_load(MEM_LBU, 32'h0000_0202, 32'h0080_0000, 5'd7, 32'h0000_0080, 1'b1, "lbu");
    test_load(MEM_LHU, 32'h0000_0202, 32'h8001_0000, 5'd8, 32'h0000_8001, 1'b1, "lhu");
    test_load(MEM_LH,  32'h0000_0202, 32'h8001_0000, 5'd8, 32'hFFFF_8001, 1'b1, "lh");
    test_load(MEM_LB,  32'h0000_0203, 32'h7F00_0000, 5'd9, 32'h0000_007F, 1'b1, "lb_pos");
    test_load(MEM_LW,  32'h0000_0300, 32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF, 1'b1, "lw");
    test_misalign(MEM_LW,  32'h0000_0306, "lw_mis");
    test_misalign(MEM_SH,  32'h0000_0101, "sh_mis");
    test_misalign(MEM_LHU, 32'h0000_0203, "lhu_mis");
    test_load(MEM_LW,  32'h0000_0400, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, "lw_rd0");
    test_stray_response();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
